// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor, one BLOCK-bit group per
// stage, with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid, in_ready        input handshake
//   A, B, C_in, sub           operands, carry in, 1 = subtract (A-B)
//   out_valid, out_ready      output handshake
//   S, C_out, ovf             result, carry out, signed overflow
module pipelined_cla_adder #(
    parameter int N     = 16,
    parameter int BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         ovf
);

    localparam int STAGES = N / BLOCK;

    logic         adv;
    logic         out_valid_q;
    logic [N-1:0] s_q;
    logic         c_out_q;
    logic         ovf_q;

    // The whole pipe moves as one unit: it only stalls when the
    // output register holds a result nobody is taking.
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign C_out     = c_out_q;
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // y carries only the not-yet-consumed operand B blocks,
        // so it shrinks by one block per stage.
        localparam int W = N - k * BLOCK;

        logic [N-1:0]     x_i;
        logic [N-1:0]     x_n;
        logic [W-1:0]     y_i;
        logic             ci;
        logic             vi;
        logic [BLOCK-1:0] ga;
        logic [BLOCK-1:0] gb;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] s;
        logic [BLOCK:0]   c;

        if (k == 0) begin : g_src
            // Subtraction as A + ~B + 1; C_in is dropped.
            assign x_i = A;
            assign y_i = sub ? ~B : B;
            assign ci  = sub | C_in;
            assign vi  = in_valid;
        end else begin : g_src
            assign x_i = g_st[k-1].g_reg.x_q;
            assign y_i = g_st[k-1].g_reg.y_q;
            assign ci  = g_st[k-1].g_reg.c_q;
            assign vi  = g_st[k-1].g_reg.v_q;
        end

        // x holds finished sum bits below this block and the
        // untouched A bits from this block upward.
        always_comb begin
            ga   = x_i[k*BLOCK +: BLOCK];
            gb   = y_i[BLOCK-1:0];
            g    = ga & gb;
            p    = ga | gb;
            c    = '0;
            c[0] = ci;
            for (int i = 0; i < BLOCK; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
            s   = ga ^ gb ^ c[BLOCK-1:0];
            x_n = x_i;
            x_n[k*BLOCK +: BLOCK] = s;
        end

        if (k < STAGES - 1) begin : g_reg
            logic [N-1:0]       x_q;
            logic [W-BLOCK-1:0] y_q;
            logic               c_q;
            logic               v_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_q <= '0;
                    y_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    x_q <= x_n;
                    y_q <= y_i[W-1:BLOCK];
                    c_q <= c[BLOCK];
                    v_q <= vi;
                end
            end
        end
    end

    // The last stage's register is the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= g_st[STAGES-1].vi;
            s_q         <= g_st[STAGES-1].x_n;
            c_out_q     <= g_st[STAGES-1].c[BLOCK];
            ovf_q       <= g_st[STAGES-1].c[BLOCK]
                         ^ g_st[STAGES-1].c[BLOCK-1];
        end
    end

endmodule
